neuron_sequencer: RTL and testbench
===================================

Name: neuron_sequencer

Overview:
- Controller that sequences one NeuronCore dot-product pass.
- On a request it reads LEN float32 operand pairs from two single-port operand RAMs (A = inputs, B = weights) and presents each pair on the core's STREAM_A/STREAM_B for HOLD cycles with START asserted.
- After a fixed core drain latency it captures STREAM_O as the result.
- Sits between the layer scheduler (REQ/DONE) and one NeuronCore instance plus its operand RAMs.

Parameters:
- DWIDTH, 32, operand/result width (IEEE-754 single).
- WORDS, 4096, depth of each operand RAM.
- SIZE, $clog2(WORDS), RAM address width.
- HOLD, 10, cycles each operand pair is held stable on the core inputs (≥1).
- CORE_LAT, 4, cycles from the last HOLD cycle to STREAM_O being valid (≥1).

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-low reset.
- REQ  in  1  start request, sampled only in IDLE.
- ABORT  in  1  cancel the current pass, sampled in any non-IDLE state.
- LEN  in  SIZE+1  number of pairs (0..WORDS).
- BASE_A  in  SIZE  first address in RAM A.
- BASE_B  in  SIZE  first address in RAM B.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when RESULT is updated.
- RESULT  out  DWIDTH  captured core output.
- ADDR_A  out  SIZE  RAM A read address.
- ADDR_B  out  SIZE  RAM B read address.
- RDATA_A  in  DWIDTH  RAM A read data; 1-cycle registered read latency.
- RDATA_B  in  DWIDTH  RAM B read data; same latency.
- CORE_START  out  1  to NeuronCore START.
- CORE_A  out  DWIDTH  to NeuronCore STREAM_A.
- CORE_B  out  DWIDTH  to NeuronCore STREAM_B.
- CORE_O  in  DWIDTH  from NeuronCore STREAM_O.

Behaviour:
- Reset (RESET=0 at an edge): state=IDLE; BUSY=0, DONE=0, CORE_START=0, RESULT=0, CORE_A=CORE_B=0, ADDR_A=ADDR_B=0. Reset wins over ABORT and REQ. Reset mid-pass discards the pass; no DONE.
- Outputs are registered; the FSM is the only driver of the core inputs.
- States: IDLE, FETCH, LOAD, HOLD, DRAIN, FIN.
- IDLE:
  - REQ=1 and LEN≠0: latch LEN, BASE_A, BASE_B; element count=0; ADDR_A/ADDR_B=BASE_A/BASE_B; go to FETCH.
  - REQ=1 and LEN=0: go to FIN; RESULT is loaded with 0; core is untouched.
- FETCH: one cycle; the RAM read is in flight.
- LOAD: one cycle; CORE_A<=RDATA_A, CORE_B<=RDATA_B, CORE_START<=1; go to HOLD.
- HOLD:
  - Lasts exactly HOLD cycles; CORE_A/CORE_B stay stable.
  - On the last cycle, if count=LEN-1 go to DRAIN.
  - Otherwise count+1, ADDR_A+1, ADDR_B+1 (each modulo WORDS, wrapping 4095→0), go to FETCH.
- DRAIN: CORE_LAT cycles with CORE_START=1 and inputs held. On the last cycle RESULT<=CORE_O; go to FIN.
- FIN: DONE=1 for one cycle; CORE_START<=0; go to IDLE (BUSY=0 next cycle).
- Per pair the pass costs HOLD+2 cycles.
- DONE is asserted exactly 1 + LEN·(HOLD+2) + CORE_LAT cycles after the REQ-accept cycle (LEN≥1).
- For LEN=0, DONE is asserted one cycle after accept.
- REQ while BUSY=1 is ignored; it is not queued.
- ABORT in any non-IDLE state: IDLE on the next edge; CORE_START=0; no DONE; RESULT unchanged.
- REQ on the cycle BUSY falls (first IDLE cycle) is accepted.
- LEN>WORDS is not legal.
- LEN is treated as count; addresses wrap; no overflow flag.

Test Plan:
- Reset: hold RESET=0 for 2 cycles with REQ=1 -> BUSY=0, DONE=0, CORE_START=0, RESULT=0x00000000.
- Single pair, HOLD=10, CORE_LAT=4, BASE=5:
  - RAM A[5]=0x40000000 (2.0), B[5]=0x40400000 (3.0); stub core drives CORE_O=0x40C00000 during DRAIN.
  - Expect ADDR_A=5; CORE_A/CORE_B=2.0/3.0 for 14 cycles; DONE 17 cycles after accept; RESULT=0x40C00000.
- LEN=3, BASE_A=4094, BASE_B=0 -> ADDR_A sequence 4094, 4095, 0 and ADDR_B 0, 1, 2; DONE at cycle 41 after accept; exactly one DONE pulse.
- LEN=0 -> DONE one cycle after accept; RESULT=0; CORE_START never asserted.
- ABORT in the 2nd HOLD of LEN=3 -> next cycle IDLE, CORE_START=0, no DONE, RESULT holds its previous value. A REQ mid-pass is ignored; a new REQ afterwards completes normally.
- Back-to-back requests: REQ held high -> second pass accepted on the first IDLE cycle after FIN; RESULT updates twice with two DONE pulses.

Source files
------------

// File: rtl/neuron_sequencer_if.sv
// Scheduler, operand-RAM and NeuronCore signals of one neuron_sequencer instance.
// The slave modport is the sequencer's view; master is the environment's.
interface neuron_sequencer_if #(
    parameter int DWIDTH = 32,
    parameter int SIZE   = 12
);
    logic              req;
    logic              abort;
    logic [SIZE:0]     len;
    logic [SIZE-1:0]   base_a;
    logic [SIZE-1:0]   base_b;
    logic              busy;
    logic              done;
    logic [DWIDTH-1:0] result;
    logic [SIZE-1:0]   addr_a;
    logic [SIZE-1:0]   addr_b;
    logic [DWIDTH-1:0] rdata_a;
    logic [DWIDTH-1:0] rdata_b;
    logic              core_start;
    logic [DWIDTH-1:0] core_a;
    logic [DWIDTH-1:0] core_b;
    logic [DWIDTH-1:0] core_o;

    modport master (
        output req, abort, len, base_a, base_b, rdata_a, rdata_b, core_o,
        input  busy, done, result, addr_a, addr_b, core_start, core_a, core_b
    );

    modport slave (
        input  req, abort, len, base_a, base_b, rdata_a, rdata_b, core_o,
        output busy, done, result, addr_a, addr_b, core_start, core_a, core_b
    );
endinterface

// File: rtl/neuron_sequencer.sv
// Sequences one NeuronCore dot-product pass: fetch LEN operand pairs, hold each
// on the core for HOLD cycles, wait CORE_LAT cycles, then capture the result.
module neuron_sequencer #(
    parameter int DWIDTH   = 32,
    parameter int WORDS    = 4096,
    parameter int SIZE     = $clog2(WORDS),
    parameter int HOLD     = 10,
    parameter int CORE_LAT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    neuron_sequencer_if.slave bus
);
    localparam int TMAX = (HOLD > CORE_LAT) ? HOLD : CORE_LAT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_HOLD, S_DRAIN, S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [SIZE:0]     len_q, len_d;
    logic [SIZE:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [SIZE-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DWIDTH-1:0] core_a_q, core_a_d, core_b_q, core_b_d;
    logic [DWIDTH-1:0] result_q, result_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        core_a_d = core_a_q;
        core_b_d = core_b_q;
        result_d = result_q;
        start_d  = start_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (bus.len != '0) begin
                        len_d    = bus.len;
                        cnt_d    = '0;
                        addr_a_d = bus.base_a;
                        addr_b_d = bus.base_b;
                        state_d  = S_FETCH;
                    end else begin
                        // Empty pass: report a zero result without touching the core.
                        result_d = '0;
                        done_d   = 1'b1;
                        state_d  = S_FIN;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                core_a_d = bus.rdata_a;
                core_b_d = bus.rdata_b;
                start_d  = 1'b1;
                tmr_d    = '0;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (tmr_q == TW'(HOLD - 1)) begin
                    tmr_d = '0;
                    if (cnt_q == len_q - (SIZE+1)'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d    = cnt_q + (SIZE+1)'(1);
                        addr_a_d = addr_a_q + SIZE'(1);
                        addr_b_d = addr_b_q + SIZE'(1);
                        state_d  = S_FETCH;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (tmr_q == TW'(CORE_LAT - 1)) begin
                    result_d = bus.core_o;
                    done_d   = 1'b1;
                    state_d  = S_FIN;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_FIN: begin
                start_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops the pass on the next edge and leaves RESULT alone.
        if (state_q != S_IDLE && bus.abort) begin
            state_d  = S_IDLE;
            start_d  = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            core_a_q <= '0;
            core_b_q <= '0;
            result_q <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            core_a_q <= core_a_d;
            core_b_q <= core_b_d;
            result_q <= result_d;
            start_q  <= start_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.addr_a     = addr_a_q;
    assign bus.addr_b     = addr_b_q;
    assign bus.core_start = start_q;
    assign bus.core_a     = core_a_q;
    assign bus.core_b     = core_b_q;
endmodule

// File: tb/tb_neuron_sequencer.sv
// Randomized bench for neuron_sequencer: RAM and core stubs plus a timing model
// derived from the per-pair cycle cost and fixed drain latency.
module tb_neuron_sequencer;
    localparam int DW    = 32;
    localparam int WORDS = 4096;
    localparam int SIZE  = 12;
    localparam int HOLD  = 10;
    localparam int CL    = 4;
    localparam int PER   = HOLD + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_sequencer_if #(.DWIDTH(DW), .SIZE(SIZE)) bus ();

    neuron_sequencer #(
        .DWIDTH(DW), .WORDS(WORDS), .SIZE(SIZE), .HOLD(HOLD), .CORE_LAT(CL)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] ram_a [WORDS];
    logic [DW-1:0] ram_b [WORDS];

    // Registered single-port reads.
    always @(posedge clk) begin
        bus.rdata_a <= ram_a[bus.addr_a];
        bus.rdata_b <= ram_b[bus.addr_b];
    end

    function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return a ^ {b[30:0], b[31]} ^ 32'h5A5A_0000;
    endfunction

    assign bus.core_o = core_fn(bus.core_a, bus.core_b);

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_result = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle after the pass (or the cycle after the abort).
    task automatic run_pass(input int len, input int ba, input int bb,
                            input int abort_at, input bit hold_req);
        int t_done = (len == 0) ? 1 : 1 + len * PER + CL;
        int last   = (abort_at > 0) ? abort_at + 1 : t_done + 1;
        int pulses = 0;
        bit started = 1'b0;
        bit poke = !hold_req && abort_at == 0;
        logic [DW-1:0] ea, eb;
        bus.req    = 1'b1;
        bus.len    = (SIZE+1)'(len);
        bus.base_a = SIZE'(ba);
        bus.base_b = SIZE'(bb);
        @(posedge clk);
        @(negedge clk);
        if (!hold_req) bus.req = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (bus.done) pulses++;
            if (bus.core_start) started = 1'b1;
            for (int k = 0; k < len; k++) begin
                ea = ram_a[(ba + k) % WORDS];
                eb = ram_b[(bb + k) % WORDS];
                if (abort_at == 0 || c <= abort_at) begin
                    if (c == 1 + k * PER) begin
                        chk("addr_a", bus.addr_a, (ba + k) % WORDS);
                        chk("addr_b", bus.addr_b, (bb + k) % WORDS);
                    end
                    if (c == 3 + k * PER || c == 2 + HOLD + k * PER) begin
                        chk("core_a", bus.core_a, ea);
                        chk("core_b", bus.core_b, eb);
                        chk("core_start", bus.core_start, 1);
                    end
                end
            end
            if (abort_at == 0 && c == t_done) begin
                exp_result = (len == 0) ? '0 :
                    core_fn(ram_a[(ba + len - 1) % WORDS], ram_b[(bb + len - 1) % WORDS]);
                chk("done_at_T", bus.done, 1);
                chk("result", bus.result, exp_result);
            end
            if (abort_at == 0 && c == t_done + 1) begin
                chk("idle_busy", bus.busy, 0);
                chk("idle_done", bus.done, 0);
            end
            if (poke && c == 5) begin
                bus.req = 1'b1;
                bus.len = (SIZE+1)'(1);
            end
            if (poke && c == 6) begin
                bus.req = 1'b0;
                bus.len = (SIZE+1)'(len);
            end
            if (abort_at > 0 && c == abort_at) bus.abort = 1'b1;
            if (abort_at > 0 && c == abort_at + 1) begin
                bus.abort = 1'b0;
                chk("abort_busy", bus.busy, 0);
                chk("abort_start", bus.core_start, 0);
                chk("abort_done", bus.done, 0);
                chk("abort_result", bus.result, exp_result);
            end
            if (c < last) @(negedge clk);
        end
        chk("done_pulses", pulses, (abort_at > 0) ? 0 : 1);
        if (len == 0) chk("len0_no_start", started, 0);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram_a[i] = $urandom;
            ram_b[i] = $urandom;
        end
        ram_a[5] = 32'h4000_0000;
        ram_b[5] = 32'h4040_0000;

        bus.req    = 1'b1;
        bus.abort  = 1'b0;
        bus.len    = (SIZE+1)'(1);
        bus.base_a = '0;
        bus.base_b = '0;
        rst_n      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_start", bus.core_start, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_addr_a", bus.addr_a, 0);
        chk("rst_core_a", bus.core_a, 0);
        bus.req = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        run_pass(1, 5, 5, 0, 1'b0);
        chk("single_result", bus.result, 32'h40C0_0000);
        run_pass(3, 4094, 0, 0, 1'b0);
        run_pass(0, 7, 9, 0, 1'b0);
        run_pass(2, 30, 40, 0, 1'b0);
        run_pass(3, 10, 20, 3 + PER + 2, 1'b0);
        run_pass(2, 11, 21, 0, 1'b0);
        run_pass(2, 100, 200, 0, 1'b1);
        run_pass(1, 4095, 4095, 0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            int l  = $urandom_range(0, 5);
            int a0 = (n % 2) ? $urandom_range(4090, 4095) : $urandom_range(0, 4095);
            int b0 = $urandom_range(0, 4095);
            bit ab = (l >= 2) && ($urandom_range(0, 3) == 0);
            run_pass(l, a0, b0, ab ? $urandom_range(2, PER * l) : 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
